// File: rtl/ascon_axil_pkg.sv
// Shared types and constants for the ASCON AXI4-Lite master: FSM states,
// AXI response codes and the register map of the ASCON core it drives.
package ascon_axil_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RSP
  } state_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  // Byte offsets of the ASCON core registers behind the AXI4-Lite slave.
  localparam logic [6:0] ASCON_CTRL   = 7'h00;
  localparam logic [6:0] ASCON_STATUS = 7'h04;
  localparam logic [6:0] ASCON_KEY0   = 7'h08;
  localparam logic [6:0] ASCON_NONCE0 = 7'h18;
  localparam logic [6:0] ASCON_DIN    = 7'h28;
  localparam logic [6:0] ASCON_DOUT   = 7'h2C;
  localparam logic [6:0] ASCON_TAG0   = 7'h30;

endpackage

// File: rtl/ascon_axil_if.sv
// AXI4-Lite bus bundle between the ASCON command master and its slave.
interface ascon_axil_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   M_AXI_AWADDR;
  logic [2:0]          M_AXI_AWPROT;
  logic                M_AXI_AWVALID;
  logic                M_AXI_AWREADY;
  logic [DATA_W-1:0]   M_AXI_WDATA;
  logic [DATA_W/8-1:0] M_AXI_WSTRB;
  logic                M_AXI_WVALID;
  logic                M_AXI_WREADY;
  logic [1:0]          M_AXI_BRESP;
  logic                M_AXI_BVALID;
  logic                M_AXI_BREADY;
  logic [ADDR_W-1:0]   M_AXI_ARADDR;
  logic [2:0]          M_AXI_ARPROT;
  logic                M_AXI_ARVALID;
  logic                M_AXI_ARREADY;
  logic [DATA_W-1:0]   M_AXI_RDATA;
  logic [1:0]          M_AXI_RRESP;
  logic                M_AXI_RVALID;
  logic                M_AXI_RREADY;

  modport master (
    output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID, input M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, input M_AXI_WREADY,
    input M_AXI_BRESP, M_AXI_BVALID, output M_AXI_BREADY,
    output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID, input M_AXI_ARREADY,
    input M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID, output M_AXI_RREADY
  );

  modport slave (
    input M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID, output M_AXI_AWREADY,
    input M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, output M_AXI_WREADY,
    output M_AXI_BRESP, M_AXI_BVALID, input M_AXI_BREADY,
    input M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID, output M_AXI_ARREADY,
    output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID, input M_AXI_RREADY
  );
endinterface

// File: rtl/ascon_axil_master.sv
// Single-outstanding AXI4-Lite master turning cmd/rsp handshakes into bus transactions.
// Optional watchdog: define ASCON_AXIL_TIMEOUT_EN to abort stalled transactions with SLVERR.
module ascon_axil_master
  import ascon_axil_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 7,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES     = 256
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESETN,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic                            rsp_timeout,
  ascon_axil_if.master                    m_axi
);

  if (C_M_AXI_DATA_WIDTH != 32 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
    $error("ascon_axil_master: data width must be 32 and TIMEOUT_CYCLES >= 1");
  end

  state_t state_q, state_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q;
  logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q;
  logic [C_M_AXI_DATA_WIDTH/8-1:0] wstrb_q;
  logic aw_done, w_done;
  logic aw_valid, w_valid, b_ready, ar_valid, r_ready;
  logic wd_hit, timeout_take;

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) state_q <= IDLE;
    else                state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    cmd_ready    = 1'b0;
    aw_valid     = 1'b0;
    w_valid      = 1'b0;
    b_ready      = 1'b0;
    ar_valid     = 1'b0;
    r_ready      = 1'b0;
    rsp_valid    = 1'b0;
    timeout_take = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = M_AXI_ARESETN;
        if (cmd_valid && M_AXI_ARESETN) state_d = cmd_write ? WR_ADDR_DATA : RD_ADDR;
      end
      WR_ADDR_DATA: begin
        aw_valid = !aw_done;
        w_valid  = !w_done;
        // Each channel may complete in either order or together.
        if ((aw_done || m_axi.M_AXI_AWREADY) && (w_done || m_axi.M_AXI_WREADY))
          state_d = WR_RESP;
      end
      WR_RESP: begin
        b_ready = 1'b1;
        if (m_axi.M_AXI_BVALID) state_d = RSP;
      end
      RD_ADDR: begin
        ar_valid = 1'b1;
        if (m_axi.M_AXI_ARREADY) state_d = RD_DATA;
      end
      RD_DATA: begin
        r_ready = 1'b1;
        if (m_axi.M_AXI_RVALID) state_d = RSP;
      end
      RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A genuine handshake on the expiry cycle takes priority over the watchdog.
    if (wd_hit && state_d == state_q) begin
      state_d      = RSP;
      timeout_take = 1'b1;
    end
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= OKAY;
    end else begin
      if (cmd_valid && cmd_ready) begin
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        wstrb_q <= cmd_wstrb;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (aw_valid && m_axi.M_AXI_AWREADY) aw_done <= 1'b1;
      if (w_valid && m_axi.M_AXI_WREADY)   w_done  <= 1'b1;
      if (timeout_take) begin
        rsp_rdata <= '0;
        rsp_resp  <= SLVERR;
      end else if (b_ready && m_axi.M_AXI_BVALID) begin
        rsp_rdata <= '0;
        rsp_resp  <= m_axi.M_AXI_BRESP;
      end else if (r_ready && m_axi.M_AXI_RVALID) begin
        rsp_rdata <= m_axi.M_AXI_RDATA;
        rsp_resp  <= m_axi.M_AXI_RRESP;
      end
    end
  end

`ifdef ASCON_AXIL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wd_cnt;
  logic             busy;

  assign busy   = (state_q inside {WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA});
  assign wd_hit = busy && (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN)                  wd_cnt <= '0;
    else if (!busy || state_d != state_q) wd_cnt <= '0;
    else                                  wd_cnt <= wd_cnt + CNT_W'(1);
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) rsp_timeout <= 1'b0;
    else if (timeout_take) rsp_timeout <= 1'b1;
    else if ((b_ready && m_axi.M_AXI_BVALID) || (r_ready && m_axi.M_AXI_RVALID))
      rsp_timeout <= 1'b0;
  end
`else
  assign wd_hit      = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  assign m_axi.M_AXI_AWADDR  = addr_q;
  assign m_axi.M_AXI_AWPROT  = 3'b000;
  assign m_axi.M_AXI_AWVALID = aw_valid;
  assign m_axi.M_AXI_WDATA   = wdata_q;
  assign m_axi.M_AXI_WSTRB   = wstrb_q;
  assign m_axi.M_AXI_WVALID  = w_valid;
  assign m_axi.M_AXI_BREADY  = b_ready;
  assign m_axi.M_AXI_ARADDR  = addr_q;
  assign m_axi.M_AXI_ARPROT  = 3'b000;
  assign m_axi.M_AXI_ARVALID = ar_valid;
  assign m_axi.M_AXI_RREADY  = r_ready;

endmodule

// File: tb/tb_ascon_axil_master.sv
// Scoreboard bench for ascon_axil_master with a delay-configurable AXI4-Lite slave model.
`timescale 1ns/1ps
module tb_ascon_axil_master;
  import ascon_axil_pkg::*;

  localparam int AW = 7;
  localparam int TO = 16;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        to;
    int          lat;   // cycles from accept to first rsp_valid; 0 = not checked
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [31:0]   cmd_wdata = '0;
  logic [3:0]    cmd_wstrb = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [31:0]   rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          rsp_timeout;

  ascon_axil_if #(.ADDR_W(AW), .DATA_W(32)) bus ();

  ascon_axil_master #(
    .C_M_AXI_ADDR_WIDTH(AW),
    .C_M_AXI_DATA_WIDTH(32),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .M_AXI_ACLK(clk),
    .M_AXI_ARESETN(rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp),
    .rsp_timeout(rsp_timeout),
    .m_axi(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- slave model (acts on the falling edge) ----------------
  int          aw_delay = 0, w_delay = 0, b_delay = 0, r_delay = 0;
  logic [1:0]  b_resp_cfg = OKAY;
  bit          ar_never = 1'b0;
  int          aw_hs = 0, w_hs = 0, ar_hs = 0;
  int          aw_wait, w_wait, b_wait, r_wait;
  bit          aw_got, w_got, b_pend, r_pend;
  logic [AW-1:0] aw_addr, ar_addr;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic [31:0] mem [32];
  bit          aw_pv, aw_pr, w_pv, w_pr, ar_pv, ar_pr;
  logic [AW-1:0] aw_pa, ar_pa;
  logic [31:0] w_pd;

  always @(negedge clk) begin
    if (!rst_n) begin
      bus.M_AXI_AWREADY = 1'b0; bus.M_AXI_WREADY = 1'b0; bus.M_AXI_ARREADY = 1'b0;
      bus.M_AXI_BVALID = 1'b0;  bus.M_AXI_BRESP = 2'b00;
      bus.M_AXI_RVALID = 1'b0;  bus.M_AXI_RRESP = 2'b00; bus.M_AXI_RDATA = '0;
      aw_wait = 0; w_wait = 0; b_wait = 0; r_wait = 0;
      aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
      aw_pv = 0; aw_pr = 0; w_pv = 0; w_pr = 0; ar_pv = 0; ar_pr = 0;
    end else begin
      if (aw_pv && !aw_pr) begin
        chk("aw_hold_valid", bus.M_AXI_AWVALID, 1);
        chk("aw_hold_addr", bus.M_AXI_AWADDR, aw_pa);
      end
      if (w_pv && !w_pr) begin
        chk("w_hold_valid", bus.M_AXI_WVALID, 1);
        chk("w_hold_data", bus.M_AXI_WDATA, w_pd);
      end
      if (ar_pv && !ar_pr && !ar_never) begin
        chk("ar_hold_valid", bus.M_AXI_ARVALID, 1);
        chk("ar_hold_addr", bus.M_AXI_ARADDR, ar_pa);
      end
      if (bus.M_AXI_AWVALID) chk("awprot", bus.M_AXI_AWPROT, 0);
      if (bus.M_AXI_ARVALID) chk("arprot", bus.M_AXI_ARPROT, 0);

      // B and R beats last one cycle; the DUT's ready was already high when raised.
      if (bus.M_AXI_BVALID) begin bus.M_AXI_BVALID = 1'b0; bus.M_AXI_BRESP = 2'b00; end
      if (bus.M_AXI_RVALID) begin bus.M_AXI_RVALID = 1'b0; bus.M_AXI_RDATA = '0; end

      bus.M_AXI_AWREADY = 1'b0;
      if (bus.M_AXI_AWVALID) begin
        if (aw_wait < aw_delay) aw_wait++;
        else begin
          bus.M_AXI_AWREADY = 1'b1; aw_wait = 0; aw_hs++;
          aw_addr = bus.M_AXI_AWADDR; aw_got = 1;
        end
      end
      bus.M_AXI_WREADY = 1'b0;
      if (bus.M_AXI_WVALID) begin
        if (w_wait < w_delay) w_wait++;
        else begin
          bus.M_AXI_WREADY = 1'b1; w_wait = 0; w_hs++;
          w_data = bus.M_AXI_WDATA; w_strb = bus.M_AXI_WSTRB; w_got = 1;
        end
      end
      if (aw_got && w_got) begin
        for (int b = 0; b < 4; b++)
          if (w_strb[b]) mem[aw_addr[6:2]][8*b +: 8] = w_data[8*b +: 8];
        aw_got = 0; w_got = 0; b_pend = 1; b_wait = 0;
      end
      if (b_pend && bus.M_AXI_BREADY) begin
        if (b_wait < b_delay) b_wait++;
        else begin
          bus.M_AXI_BVALID = 1'b1; bus.M_AXI_BRESP = b_resp_cfg; b_pend = 0;
        end
      end

      bus.M_AXI_ARREADY = 1'b0;
      if (bus.M_AXI_ARVALID && !ar_never) begin
        bus.M_AXI_ARREADY = 1'b1; ar_hs++;
        ar_addr = bus.M_AXI_ARADDR; r_pend = 1; r_wait = 0;
      end
      if (r_pend && bus.M_AXI_RREADY) begin
        if (r_wait < r_delay) r_wait++;
        else begin
          bus.M_AXI_RVALID = 1'b1; bus.M_AXI_RRESP = OKAY;
          bus.M_AXI_RDATA = mem[ar_addr[6:2]]; r_pend = 0;
        end
      end

      aw_pv = bus.M_AXI_AWVALID; aw_pr = bus.M_AXI_AWREADY; aw_pa = bus.M_AXI_AWADDR;
      w_pv  = bus.M_AXI_WVALID;  w_pr  = bus.M_AXI_WREADY;  w_pd  = bus.M_AXI_WDATA;
      ar_pv = bus.M_AXI_ARVALID; ar_pr = bus.M_AXI_ARREADY; ar_pa = bus.M_AXI_ARADDR;
    end
  end

  // ---------------- scoreboard monitor ----------------
  exp_t sb[$];
  exp_t cur;
  bit   outstanding = 0, rsp_active = 0;
  int   cyc = 0, accept_cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      sb.delete();
      outstanding = 0;
      rsp_active = 0;
    end else begin
      chk("cmd_ready", cmd_ready, !outstanding);
      if (rsp_valid) begin
        if (!rsp_active) begin
          if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_rsp: got rdata 0x%08h resp %0d with nothing expected", rsp_rdata, rsp_resp);
          end else begin
            cur = sb.pop_front();
            rsp_active = 1;
            if (cur.lat != 0) chk("latency", cyc - accept_cyc, cur.lat);
          end
        end
        if (rsp_active) begin
          chk("rsp_rdata", rsp_rdata, cur.rdata);
          chk("rsp_resp", rsp_resp, cur.resp);
          chk("rsp_timeout", rsp_timeout, cur.to);
        end
        if (rsp_ready) begin
          rsp_active = 0;
          outstanding = 0;
        end
      end
      if (cmd_valid && cmd_ready) begin
        outstanding = 1;
        accept_cyc = cyc;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input bit wr, input logic [AW-1:0] a, input logic [31:0] d,
                       input logic [3:0] s, input exp_t e);
    int n = 0;
    sb.push_back(e);
    cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (!cmd_ready) begin
      failures++;
      $display("FAIL cmd_accept: cmd_ready stayed 0 for %0d cycles, required 1", n);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while ((outstanding || sb.size() != 0) && n < budget) begin @(posedge clk); #1; n++; end
    checks++;
    if (outstanding || sb.size() != 0) begin
      failures++;
      $display("FAIL wait_done: %0d responses still pending after %0d cycles, required 0", sb.size(), budget);
      sb.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
    chk({tag, "_rsp_resp"}, rsp_resp, 0);
    chk({tag, "_rsp_timeout"}, rsp_timeout, 0);
    chk({tag, "_awvalid"}, bus.M_AXI_AWVALID, 0);
    chk({tag, "_wvalid"}, bus.M_AXI_WVALID, 0);
    chk({tag, "_bready"}, bus.M_AXI_BREADY, 0);
    chk({tag, "_arvalid"}, bus.M_AXI_ARVALID, 0);
    chk({tag, "_rready"}, bus.M_AXI_RREADY, 0);
    chk({tag, "_awaddr"}, bus.M_AXI_AWADDR, 0);
    chk({tag, "_araddr"}, bus.M_AXI_ARADDR, 0);
    chk({tag, "_wdata"}, bus.M_AXI_WDATA, 0);
    chk({tag, "_wstrb"}, bus.M_AXI_WSTRB, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int n;
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Write with AWREADY 3 cycles late, WREADY immediate.
    aw_delay = 3; w_delay = 0; aw_hs = 0; w_hs = 0;
    issue(1'b1, 7'h00, 32'h12345678, 4'hF, '{32'h0, OKAY, 1'b0, 6});
    wait_done(100);
    chk("t1_aw_handshakes", aw_hs, 1);
    chk("t1_w_handshakes", w_hs, 1);
    chk("t1_mem", mem[0], 32'h12345678);

    // Read with RVALID 2 cycles late.
    aw_delay = 0; r_delay = 2; ar_hs = 0;
    issue(1'b0, 7'h00, 32'h0, 4'h0, '{32'h12345678, OKAY, 1'b0, 5});
    wait_done(100);
    chk("t2_ar_handshakes", ar_hs, 1);
    r_delay = 0;

    // SLVERR write, response held while consumer stalls.
    b_resp_cfg = SLVERR; rsp_ready = 1'b0;
    issue(1'b1, 7'h7C, 32'hDEADBEEF, 4'hF, '{32'h0, SLVERR, 1'b0, 3});
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    chk("t3_rsp_valid", rsp_valid, 1);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      chk("t3_hold_valid", rsp_valid, 1);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1; b_resp_cfg = OKAY;
    wait_done(50);

    // Back-to-back commands against a zero-wait slave.
    issue(1'b1, 7'h04, 32'hCAFE0004, 4'hF, '{32'h0, OKAY, 1'b0, 3});
    issue(1'b1, 7'h08, 32'h0BADF00D, 4'h3, '{32'h0, OKAY, 1'b0, 3});
    issue(1'b0, 7'h04, 32'h0, 4'h0, '{32'hCAFE0004, OKAY, 1'b0, 3});
    issue(1'b0, 7'h08, 32'h0, 4'h0, '{32'h0000F00D, OKAY, 1'b0, 3});
    wait_done(100);

    // Reset while waiting for BVALID; the write's response must never appear.
    b_delay = 50;
    issue(1'b1, 7'h10, 32'h55AA55AA, 4'hF, '{32'h0, OKAY, 1'b0, 0});
    n = 0;
    while (!bus.M_AXI_BREADY && n < 50) begin @(negedge clk); n++; end
    chk("t5_in_wr_resp", bus.M_AXI_BREADY, 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1; b_delay = 0;
    @(posedge clk); #1;
    issue(1'b0, 7'h00, 32'h0, 4'h0, '{32'h12345678, OKAY, 1'b0, 3});
    wait_done(100);

`ifdef ASCON_AXIL_TIMEOUT_EN
    // ARREADY never arrives: TO cycles in RD_ADDR plus the accept cycle.
    ar_never = 1'b1;
    issue(1'b0, 7'h20, 32'h0, 4'h0, '{32'h0, SLVERR, 1'b1, TO + 1});
    wait_done(100);
    chk("t6_arvalid_dropped", bus.M_AXI_ARVALID, 0);
    ar_never = 1'b0;
    issue(1'b0, 7'h04, 32'h0, 4'h0, '{32'hCAFE0004, OKAY, 1'b0, 3});
    wait_done(100);
`endif

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
